// File: rtl/cp_cluster_pkg.sv
// Shared constants and helpers for the compute-cluster MAC blocks.
package cp_cluster_pkg;

    localparam int CP_D_WIDTH  = 72;
    localparam int MAC_LATENCY = 6;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past ptr.
module rr_arbiter
    import cp_cluster_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          any
);

    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mac_core_arbiter.sv
// Round-robin front end sharing one fixed-latency multiply-accumulate core,
// tracking in-flight ops and returning results tagged with requester ID.
module mac_core_arbiter #(
    parameter int CP_D_WIDTH  = cp_cluster_pkg::CP_D_WIDTH,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = cp_cluster_pkg::clog2(NUM_REQ),
    parameter int MAC_LATENCY = cp_cluster_pkg::MAC_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*CP_D_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*CP_D_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*CP_D_WIDTH-1:0] req_c,
    input  logic                          flush,
    output logic [CP_D_WIDTH-1:0]         mac_a,
    output logic [CP_D_WIDTH-1:0]         mac_b,
    output logic [CP_D_WIDTH-1:0]         mac_c,
    output logic                          mac_ce,
    output logic                          mac_sclr,
    input  logic [2*CP_D_WIDTH-1:0]       mac_p,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [2*CP_D_WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]               res_id,
    output logic [cp_cluster_pkg::clog2(MAC_LATENCY+1)-1:0] inflight
);

    localparam int CW = cp_cluster_pkg::clog2(MAC_LATENCY + 1);
    localparam int L  = MAC_LATENCY;

    logic [L-1:0]            vld;
    logic [L-1:0][ID_W-1:0]  id_q;
    logic [ID_W-1:0]         rr_ptr;
    logic                    sclr_q;
    logic [CW-1:0]           cnt;

    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_id;
    logic                    any;
    logic                    issue;
    logic                    res_fire;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    // The whole core freezes while the tail result waits for downstream.
    assign mac_ce    = ~(vld[L-1] & ~res_ready);
    assign issue     = any & mac_ce & ~sclr_q & ~flush;
    assign req_ready = issue ? grant : '0;
    assign mac_sclr  = sclr_q;
    assign res_valid = vld[L-1] & ~sclr_q;
    assign res_id    = id_q[L-1];
    assign res_data  = mac_p;
    assign res_fire  = res_valid & res_ready;
    assign inflight  = cnt;

    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        if (issue) begin
            mac_a = req_a[int'(grant_id)*CP_D_WIDTH +: CP_D_WIDTH];
            mac_b = req_b[int'(grant_id)*CP_D_WIDTH +: CP_D_WIDTH];
            mac_c = req_c[int'(grant_id)*CP_D_WIDTH +: CP_D_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= '0;
            id_q   <= '0;
            rr_ptr <= ID_W'(NUM_REQ - 1);
            sclr_q <= 1'b1;
            cnt    <= '0;
        end else begin
            sclr_q <= flush;
            if (mac_ce) begin
                id_q <= {id_q[L-2:0], grant_id};
            end
            if (issue) begin
                rr_ptr <= grant_id;
            end
            if (flush) begin
                vld <= '0;
                cnt <= '0;
            end else begin
                if (mac_ce) begin
                    vld <= {vld[L-2:0], issue};
                end
                if (issue && !res_fire) begin
                    cnt <= cnt + CW'(1);
                end else if (!issue && res_fire) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_core_arbiter.sv
// Self-checking bench: behavioural core plus a queue-based scoreboard model.
module tb_mac_core_arbiter;

    localparam int W  = 72;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int L  = 6;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } op_t;

    typedef struct {
        logic [IW-1:0]  id;
        logic [2*W-1:0] data;
        int             age;
    } ent_t;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic [NR*W-1:0]   req_c;
    logic              flush;
    logic [W-1:0]      mac_a;
    logic [W-1:0]      mac_b;
    logic [W-1:0]      mac_c;
    logic              mac_ce;
    logic              mac_sclr;
    logic [2*W-1:0]    mac_p;
    logic              res_valid;
    logic              res_ready;
    logic [2*W-1:0]    res_data;
    logic [IW-1:0]     res_id;
    logic [2:0]        inflight;

    mac_core_arbiter #(
        .CP_D_WIDTH  (W),
        .NUM_REQ     (NR),
        .ID_W        (IW),
        .MAC_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .flush     (flush),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_ce    (mac_ce),
        .mac_sclr  (mac_sclr),
        .mac_p     (mac_p),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared multiply-accumulate core.
    logic [2*W-1:0] pipe [L];
    always @(posedge clk) begin
        if (mac_sclr) begin
            for (int j = 0; j < L; j++) pipe[j] <= '0;
        end else if (mac_ce) begin
            pipe[0] <= (2*W)'(mac_a) * (2*W)'(mac_b) + (2*W)'(mac_c);
            for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
        end
    end
    assign mac_p = pipe[L-1];

    int tests;
    int fails;
    int cyc;
    int stall_cnt;
    int res_count;
    int acc_cyc;
    op_t  opq [NR][$];
    ent_t q [$];
    int   grant_log [$];
    logic [2*W-1:0] res_log [$];
    int   res_cyc [$];
    int   rr_last;
    logic sclr_m;
    logic [2*W-1:0] last_data;
    logic [IW-1:0]  last_id;

    task automatic chk(input string tag, input logic [2*W-1:0] obs,
                       input logic [2*W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rr_last = NR - 1;
        sclr_m  = 1'b1;
        grant_log.delete();
    endtask

    function automatic int ref_grant();
        int best;
        int bd;
        int d;
        best = -1;
        bd   = NR + 1;
        for (int i = 0; i < NR; i++) begin
            d = (i - rr_last - 1 + NR) % NR;
            if (req_valid[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic apply_req();
        for (int i = 0; i < NR; i++) begin
            if (opq[i].size() > 0) begin
                req_valid[i]     = 1'b1;
                req_a[i*W +: W]  = opq[i][0].a;
                req_b[i*W +: W]  = opq[i][0].b;
                req_c[i*W +: W]  = opq[i][0].c;
            end else begin
                req_valid[i]     = 1'b0;
                req_a[i*W +: W]  = '0;
                req_b[i*W +: W]  = '0;
                req_c[i*W +: W]  = '0;
            end
        end
    endtask

    task automatic push_op(input int r, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] c);
        op_t o;
        o.a = a;
        o.b = b;
        o.c = c;
        opq[r].push_back(o);
    endtask

    task automatic cycle();
        logic tail;
        logic erv;
        logic ece;
        logic eiss;
        logic [NR-1:0] erdy;
        int   gid;
        ent_t e;
        apply_req();
        @(negedge clk);
        tail = (q.size() > 0) && (q[0].age == L);
        erv  = tail && !sclr_m;
        ece  = !(tail && !res_ready);
        gid  = ref_grant();
        eiss = (gid >= 0) && ece && !sclr_m && !flush && !rst;
        erdy = eiss ? NR'(1 << gid) : '0;
        chk("res_valid", 144'(res_valid), 144'(erv));
        chk("mac_ce", 144'(mac_ce), 144'(ece));
        chk("mac_sclr", 144'(mac_sclr), 144'(sclr_m));
        chk("req_ready", 144'(req_ready), 144'(erdy));
        chk("inflight", 144'(inflight), 144'(q.size()));
        if (!mac_ce) stall_cnt++;
        if (erv) begin
            chk("res_data", res_data, q[0].data);
            chk("res_id", 144'(res_id), 144'(q[0].id));
        end
        if (eiss) begin
            chk("mac_a", 144'(mac_a), 144'(opq[gid][0].a));
            chk("mac_b", 144'(mac_b), 144'(opq[gid][0].b));
            chk("mac_c", 144'(mac_c), 144'(opq[gid][0].c));
            grant_log.push_back(gid);
            acc_cyc = cyc;
            e.id   = IW'(gid);
            e.data = (2*W)'(opq[gid][0].a) * (2*W)'(opq[gid][0].b)
                   + (2*W)'(opq[gid][0].c);
            e.age  = 1;
        end else begin
            chk("mac_a_idle", 144'(mac_a), 144'(0));
        end
        if (erv && res_ready) begin
            res_count++;
            last_data = res_data;
            last_id   = res_id;
            res_log.push_back(res_data);
            res_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (flush) begin
            q.delete();
            sclr_m = 1'b1;
        end else begin
            sclr_m = 1'b0;
            if (erv && res_ready) void'(q.pop_front());
            if (ece) foreach (q[j]) q[j].age++;
            if (eiss) begin
                q.push_back(e);
                rr_last = gid;
            end
        end
        if (eiss) void'(opq[gid].pop_front());
        cyc++;
        #1;
    endtask

    function automatic bit idle();
        bit r;
        r = (q.size() == 0);
        for (int i = 0; i < NR; i++) if (opq[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (!idle() && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 144'(idle()), 144'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n0;
        int r;
        logic [2*W-1:0] wide;
        tests = 0; fails = 0; cyc = 0; stall_cnt = 0; res_count = 0;
        acc_cyc = 0; last_data = '0; last_id = '0;
        req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
        flush = 1'b0; res_ready = 1'b1; rst = 1'b1;
        model_reset();
        #1;
        chk("reset_ready", 144'(req_ready), 144'(0));
        chk("reset_sclr", 144'(mac_sclr), 144'(1));
        chk("reset_ce", 144'(mac_ce), 144'(1));
        do_reset();

        // single op
        push_op(1, 72'd3, 72'd5, 72'd7);
        res_cyc.delete();
        drain(40);
        chk("single_data", last_data, 144'd22);
        chk("single_id", 144'(last_id), 144'(1));
        chk("single_lat", 144'(res_cyc[0] - acc_cyc), 144'(L));

        // fairness from a fresh reset
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++)
                push_op(i, 72'(i + 1), 72'd10, 72'd0);
        res_log.delete();
        res_cyc.delete();
        drain(60);
        chk("fair_cnt", 144'(grant_log.size()), 144'(8));
        for (int k = 0; k < 8; k++) begin
            chk("fair_grant", 144'(grant_log[k]), 144'(k % NR));
            chk("fair_res", res_log[k], 144'(((k % NR) + 1) * 10));
            if (k > 0) chk("fair_b2b", 144'(res_cyc[k]), 144'(res_cyc[k-1] + 1));
        end

        // backpressure
        grant_log.delete();
        for (int k = 0; k < 3; k++)
            push_op(2, 72'($urandom), 72'($urandom), 72'($urandom));
        n0 = 0;
        while (grant_log.size() < 3 && n0 < 20) begin
            cycle();
            n0++;
        end
        res_ready = 1'b0;
        push_op(0, 72'd9, 72'd9, 72'd9);
        stall_cnt = 0;
        n0 = res_count;
        repeat (10) cycle();
        chk("bp_stall", 144'(stall_cnt), 144'(7));
        chk("bp_nores", 144'(res_count), 144'(n0));
        res_ready = 1'b1;
        drain(40);
        chk("bp_all", 144'(res_count), 144'(n0 + 4));

        // wide operands
        push_op(3, {W{1'b1}}, {W{1'b1}}, {W{1'b1}});
        drain(40);
        wide = {{W{1'b1}}, {W{1'b0}}};
        chk("wide", last_data, wide);

        // flush with ops in flight
        grant_log.delete();
        for (int i = 0; i < NR; i++) push_op(i, 72'(i + 2), 72'd3, 72'd1);
        n0 = 0;
        while (grant_log.size() < 4 && n0 < 20) begin
            cycle();
            n0++;
        end
        n0 = res_count;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (10) cycle();
        chk("flush_nores", 144'(res_count), 144'(n0));
        chk("flush_infl", 144'(inflight), 144'(0));
        push_op(2, 72'd11, 72'd4, 72'd2);
        drain(40);
        chk("flush_after", last_data, 144'd46);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, NR - 1);
                if (opq[r].size() < 3)
                    push_op(r, 72'({$urandom(), $urandom(), $urandom()}),
                            72'({$urandom(), $urandom(), $urandom()}),
                            72'({$urandom(), $urandom(), $urandom()}));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            cycle();
        end
        flush = 1'b0;
        res_ready = 1'b1;
        drain(100);

        // asynchronous reset mid-stream
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 2; k++) push_op(i, 72'(k + 1), 72'd7, 72'd0);
        repeat (4) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", 144'(res_valid), 144'(0));
        chk("arst_ready", 144'(req_ready), 144'(0));
        chk("arst_sclr", 144'(mac_sclr), 144'(1));
        chk("arst_infl", 144'(inflight), 144'(0));
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        chk("arst_first", 144'(grant_log[0]), 144'(0));
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
